// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, byte holding register with ack handshake.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point, decided one cycle later.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [15:0] DECIDE_CNT = 16'(CLKS_PER_BIT / 2);
`else
  localparam logic [15:0] DECIDE_CNT = 16'(CLKS_PER_BIT / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        rx_meta_q, rx_s_q;
  logic        tick;
  logic        bit_val;
  logic        stop_tick;

`ifdef UART_RX_MAJORITY_EN
  logic rx_h1_q, rx_h2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_h1_q <= 1'b1;
      rx_h2_q <= 1'b1;
    end else begin
      rx_h1_q <= rx_s_q;
      rx_h2_q <= rx_h1_q;
    end
  end

  // Counter sits one past the sample point: rx_h2_q/rx_h1_q/rx_s_q are points -1/0/+1.
  assign bit_val = (rx_s_q & rx_h1_q) | (rx_s_q & rx_h2_q) | (rx_h1_q & rx_h2_q);
`else
  assign bit_val = rx_s_q;
`endif

  // cnt_q is 0 on t0+1, so DECIDE_CNT lands on t0 + k*CLKS_PER_BIT + CLKS_PER_BIT/2.
  assign tick      = (cnt_q == DECIDE_CNT);
  assign stop_tick = (state_q == S_STOP) && tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == LAST_CNT) ? 16'd0 : 16'(cnt_q + 16'd1);
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          if (bit_val) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {bit_val, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick) state_d = bit_val ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A byte landing in the same cycle as ack wins over the ack's clear of valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;
    if (ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (stop_tick) begin
      if (bit_val) begin
        if (valid_q && !ack) begin
          ovr_d = 1'b1;
        end else begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16 with a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int N = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // rx drive cycle -> t0 is 2 cycles; t0 -> visible valid/frame_err is 9*N+N/2+1.
  localparam int LAT = 2 + 9*N + N/2 + 1 + MAJ;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst), .rx(rx), .ack(ack),
    .data(data), .valid(valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_start = 0;
  int valid_rise_cyc = -1;
  int ferr_cyc = -1;
  int ferr_cnt = 0;
  int busy_cnt = 0;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1 && valid_prev !== 1'b1) valid_rise_cyc = cyc;
    if (frame_err === 1'b1) begin
      ferr_cnt = ferr_cnt + 1;
      ferr_cyc = cyc;
    end
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    valid_prev = valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // Drives the first ncyc cycles of a frame; spike inverts the line on one cycle offset.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int spike, input int ncyc);
    logic v;
    for (int c = 0; c < ncyc; c++) begin
      if (c < N)          v = 1'b0;
      else if (c < 9 * N) v = b[(c / N) - 1];
      else                v = stop_b;
      if (c == spike) v = ~v;
      @(posedge clk);
      #1;
      if (c == 0) last_start = cyc;
      rx = v;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rx = 1'b1;
    end
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_ack();
    @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b required 0", valid); end
    checks++; if (data !== 8'h00)     begin errors++; $display("FAIL reset_data: got %h required 00", data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b required 0", overrun); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
  endtask

  task automatic test_single_frame();
    int f0;
    bit got;
    logic [7:0] exp;
    idle(5);
    f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, 10 * N);
    idle(N);
    checks++; if (valid_rise_cyc - last_start != LAT) begin errors++; $display("FAIL single_latency: got %0d required %0d", valid_rise_cyc - last_start, LAT); end
    wait_valid(got);
    exp = exp_q.pop_front();
    checks++; if (!got)              begin errors++; $display("FAIL single_valid: got 0 required 1"); end
    checks++; if (data !== exp)      begin errors++; $display("FAIL single_data: got %h required %h", data, exp); end
    checks++; if (ferr_cnt != f0)    begin errors++; $display("FAIL single_frame_err: got %0d pulses required 0", ferr_cnt - f0); end
    checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL single_overrun: got %b required 0", overrun); end
    do_ack();
    @(negedge clk);
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL single_ack_clear: got %b required 0", valid); end
  endtask

  task automatic test_back_to_back();
    int f0;
    idle(N);
    f0 = ferr_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    fork
      begin
        send_frame(8'h00, 1'b1, -1, 10 * N);
        send_frame(8'hFF, 1'b1, -1, 10 * N);
        idle(2 * N);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          bit got;
          logic [7:0] exp;
          wait_valid(got);
          checks++;
          if (!got) begin
            errors++; $display("FAIL b2b_valid_%0d: got 0 required 1", k);
          end else begin
            exp = exp_q.pop_front();
            if (data !== exp) begin errors++; $display("FAIL b2b_data_%0d: got %h required %h", k, data, exp); end
            do_ack();
          end
        end
      end
    join
    checks++; if (ferr_cnt != f0)     begin errors++; $display("FAIL b2b_frame_err: got %0d pulses required 0", ferr_cnt - f0); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL b2b_overrun: got %b required 0", overrun); end
    checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL b2b_scoreboard: got %0d left required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_glitch();
    int f0, b0, bh;
    idle(2 * N);
    f0 = ferr_cnt;
    b0 = busy_cnt;
    repeat (4) begin
      @(posedge clk);
      #1 rx = 1'b0;
    end
    idle(3 * N);
    bh = busy_cnt - b0;
    checks++; if (bh < 1 || bh >= 9 + MAJ) begin errors++; $display("FAIL glitch_busy_cycles: got %0d required 1..%0d", bh, 8 + MAJ); end
    checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL glitch_valid: got %b required 0", valid); end
    checks++; if (ferr_cnt != f0)  begin errors++; $display("FAIL glitch_frame_err: got %0d pulses required 0", ferr_cnt - f0); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL glitch_idle: got busy=%b required 0", busy); end
  endtask

  task automatic test_frame_error();
    int f0;
    idle(N);
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1, 10 * N);
    repeat (40) begin
      @(posedge clk);
      #1 rx = 1'b0;
    end
    @(negedge clk);
    checks++; if (ferr_cnt - f0 != 1)              begin errors++; $display("FAIL ferr_pulses: got %0d required 1", ferr_cnt - f0); end
    checks++; if (ferr_cyc - last_start != LAT)    begin errors++; $display("FAIL ferr_latency: got %0d required %0d", ferr_cyc - last_start, LAT); end
    checks++; if (busy !== 1'b1)                   begin errors++; $display("FAIL ferr_break_hold: got busy=%b required 1", busy); end
    checks++; if (valid !== 1'b0)                  begin errors++; $display("FAIL ferr_valid: got %b required 0", valid); end
    idle(N);
    checks++; if (busy !== 1'b0)                   begin errors++; $display("FAIL ferr_release: got busy=%b required 0", busy); end
    checks++; if (ferr_cnt - f0 != 1 || valid !== 1'b0) begin errors++; $display("FAIL ferr_no_second_frame: got pulses=%0d valid=%b required 1 and 0", ferr_cnt - f0, valid); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    idle(N);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, 10 * N);
    send_frame(8'h22, 1'b1, -1, 10 * N);
    idle(N);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL ovr_valid: got %b required 1", valid); end
    checks++; if (data !== exp)     begin errors++; $display("FAIL ovr_data: got %h required %h", data, exp); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b required 1", overrun); end
    do_ack();
    @(negedge clk);
    checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL ovr_ack_valid: got %b required 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack_clear: got %b required 0", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    bit got;
    logic [7:0] exp;
    idle(N);
    send_frame(8'h5A, 1'b1, -1, 4 * N + N / 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2 * N);
    @(negedge clk);
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_abort: got valid=%b busy=%b required 0 0", valid, busy); end
    checks++; if (data !== 8'h00)   begin errors++; $display("FAIL rst_data: got %h required 00", data); end
    exp_q.push_back(8'h69);
    send_frame(8'h69, 1'b1, -1, 10 * N);
    idle(N);
    wait_valid(got);
    exp = exp_q.pop_front();
    checks++; if (!got || data !== exp) begin errors++; $display("FAIL rst_recover: got valid=%b data=%h required 1 %h", got, data, exp); end
    do_ack();
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority_spike();
    bit got;
    logic [7:0] exp;
    idle(N);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 2 * N + N / 2, 10 * N);
    idle(N);
    wait_valid(got);
    exp = exp_q.pop_front();
    checks++; if (!got || data !== exp) begin errors++; $display("FAIL maj_spike: got valid=%b data=%h required 1 %h", got, data, exp); end
    do_ack();
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
`ifdef UART_RX_MAJORITY_EN
    test_majority_spike();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
